poly_byte_encode12: RTL

Streaming 12-bit polynomial packer (Kyber ByteEncode_12), the inverse of the parse byte-to-coefficient unpacking. Accepts 256 coefficients one per handshake and emits 384 bytes, three bytes per coefficient pair. Sits between the NTT/polynomial arithmetic datapath and the byte-oriented hash/serialisation path (public key, ciphertext packing).

---
 rtl/poly_byte_encode12.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/poly_byte_encode12.sv
// -----------------------------------------------------------------------------
// poly_byte_encode12
//
// Purpose:
//   Streaming 12-bit polynomial packer (Kyber ByteEncode_12). It takes NCOEFF
//   coefficients, one per handshake, and emits 3*NCOEFF/2 bytes. Each pair of
//   coefficients (c0, c1) becomes three bytes:
//       byte0 = c0[7:0]
//       byte1 = {c1[3:0], c0[11:8]}
//       byte2 = c1[11:4]
//   This is the exact inverse of the parse unpacking:
//       d1 = b0 + 256*(b1%16), d2 = (b1>>4) + 16*b2
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   coeff_valid  input coefficient valid
//   coeff_ready  block accepts a coefficient this cycle (registered)
//   coeff_data   coefficient; bits [11:0] used
//   out_valid    output byte valid (registered)
//   out_ready    downstream accepts byte
//   out_byte     packed byte (registered, held while stalled)
//   out_last     high with the final byte of the polynomial
//   done         one-cycle pulse after the final byte is accepted
//
// Configuration:
//   PARSE_ENC_CANON_EN  when defined, every accepted coefficient (< 2Q) is
//                       reduced into [0, Q) by one conditional subtraction.
//                       When undefined, coeff_data[11:0] is stored as-is.
// -----------------------------------------------------------------------------
module poly_byte_encode12 #(
    parameter int Q      = 3329,
    parameter int NCOEFF = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coeff_valid,
    output logic        coeff_ready,
    input  logic [15:0] coeff_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        out_last,
    output logic        done
);

    localparam int             NPAIR     = NCOEFF / 2;
    localparam int             PW        = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [PW-1:0]  LAST_PAIR = PW'(NPAIR - 1);
    localparam logic [15:0]    Q_W       = 16'(Q);

    typedef enum logic [2:0] {
        GET0,
        GET1,
        SEND0,
        SEND1,
        SEND2
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   pair_q;
    logic [11:0]     c0_q;
    logic [11:0]     c1_q;
    logic            coeff_ready_q;
    logic            out_valid_q;
    logic [7:0]      out_byte_q;
    logic            out_last_q;
    logic            done_q;

    // Value that will be captured into c0/c1 on an accepted coefficient.
    logic [11:0]     coeff_d;

`ifdef PARSE_ENC_CANON_EN
    // Single conditional subtraction; input is guaranteed below 2Q so the
    // result always lands in [0, Q) and fits in 12 bits.
    logic [15:0] coeff_red;
    logic        unused_hi;

    assign coeff_red = (coeff_data >= Q_W) ? (coeff_data - Q_W) : coeff_data;
    assign coeff_d   = coeff_red[11:0];
    assign unused_hi = ^coeff_red[15:12];
`else
    // Upper nibble is discarded; the modulus only matters for the reduction.
    logic unused_hi;

    assign coeff_d   = coeff_data[11:0];
    assign unused_hi = ^{coeff_data[15:12], Q_W};
`endif

    logic coeff_fire;
    logic out_fire;

    assign coeff_fire = coeff_valid && coeff_ready_q;
    assign out_fire   = out_valid_q && out_ready;

    // The FSM pre-computes the outputs of the state it is moving into, so all
    // handshake outputs come straight from flops. After reset coeff_ready is
    // low for one cycle while GET0 raises it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= GET0;
            pair_q        <= '0;
            c0_q          <= '0;
            c1_q          <= '0;
            coeff_ready_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_byte_q    <= '0;
            out_last_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                GET0: begin
                    coeff_ready_q <= 1'b1;
                    if (coeff_fire) begin
                        c0_q    <= coeff_d;
                        state_q <= GET1;
                    end
                end
                GET1: begin
                    coeff_ready_q <= 1'b1;
                    if (coeff_fire) begin
                        c1_q          <= coeff_d;
                        coeff_ready_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        out_byte_q    <= c0_q[7:0];
                        state_q       <= SEND0;
                    end
                end
                SEND0: begin
                    if (out_fire) begin
                        out_byte_q <= {c1_q[3:0], c0_q[11:8]};
                        state_q    <= SEND1;
                    end
                end
                SEND1: begin
                    if (out_fire) begin
                        out_byte_q <= c1_q[11:4];
                        out_last_q <= (pair_q == LAST_PAIR);
                        state_q    <= SEND2;
                    end
                end
                SEND2: begin
                    if (out_fire) begin
                        out_valid_q   <= 1'b0;
                        out_last_q    <= 1'b0;
                        coeff_ready_q <= 1'b1;
                        if (pair_q == LAST_PAIR) begin
                            pair_q <= '0;
                            done_q <= 1'b1;
                        end else begin
                            pair_q <= pair_q + PW'(1);
                        end
                        state_q <= GET0;
                    end
                end
                default: begin
                    state_q       <= GET0;
                    coeff_ready_q <= 1'b0;
                    out_valid_q   <= 1'b0;
                    out_last_q    <= 1'b0;
                end
            endcase
        end
    end

    assign coeff_ready = coeff_ready_q;
    assign out_valid   = out_valid_q;
    assign out_byte    = out_byte_q;
    assign out_last    = out_last_q;
    assign done        = done_q;

endmodule
